// File: rtl/sequenciador_programa.sv
// Program sequencer: holds a small program image and feeds it word by word to a
// multicycle processor, pacing issue on ProcDone with a watchdog on each instruction.
module sequenciador_programa #(
   parameter int PROG_DEPTH = 16,
   parameter int WD_LIMIT   = 7
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        LoadEn,
   input  logic [3:0]  LoadAddr,
   input  logic [15:0] LoadData,
   input  logic        Start,
   input  logic [4:0]  Length,
   input  logic        ProcDone,
   output logic [15:0] DIN,
   output logic        Run,
   output logic        Busy,
   output logic        Finished,
   output logic        Error,
   output logic [3:0]  PC,
   output logic [4:0]  InstrCount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_IMM,
      S_WAIT,
      S_FINISH
   } state_t;

   localparam logic [2:0] WD_LAST = 3'(WD_LIMIT - 1);
   localparam logic [2:0] OP_MVI  = 3'b001;

   state_t      state_q, state_d;
   logic [3:0]  pc_q, pc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  len_q, len_d;
   logic        err_q, err_d;
   logic [2:0]  wd_q, wd_d;
   logic [15:0] mem_q [PROG_DEPTH];

   logic [15:0] word;
   logic [4:0]  len_eff;
   logic [4:0]  pc_inc;
   logic        last_word;
   logic        is_mvi;
   logic        mem_we;

   assign word      = mem_q[pc_q];
   assign len_eff   = (Length > 5'd16) ? 5'd16 : Length;
   assign pc_inc    = {1'b0, pc_q} + 5'd1;
   assign last_word = (pc_inc >= len_q);
   assign is_mvi    = (word[8:6] == OP_MVI);
   assign mem_we    = LoadEn && (state_q == S_IDLE) && !Reset;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      err_d   = err_q;
      wd_d    = wd_q;
      DIN     = 16'h0000;
      Run     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               err_d = 1'b0;
               len_d = len_eff;
               if (len_eff != 5'd0) begin
                  pc_d    = 4'd0;
                  cnt_d   = 5'd0;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_ISSUE: begin
            Run  = 1'b1;
            DIN  = word;
            wd_d = 3'd0;
            // An mvi needs its immediate word inside the program, otherwise the run is malformed.
            if (is_mvi) begin
               if (!last_word) begin
                  pc_d    = pc_q + 4'd1;
                  state_d = S_IMM;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_IMM, S_WAIT: begin
            DIN = word;
            if (ProcDone) begin
               cnt_d = cnt_q + 5'd1;
               wd_d  = 3'd0;
               if (last_word) begin
                  state_d = S_FINISH;
               end else begin
                  pc_d    = pc_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               wd_d    = 3'd0;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + 3'd1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= 4'd0;
         cnt_q   <= 5'd0;
         len_q   <= 5'd0;
         err_q   <= 1'b0;
         wd_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   // Program image is deliberately outside the reset domain so a reset keeps the loaded program.
   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem_q[LoadAddr] <= LoadData;
      end
   end

   assign Busy       = (state_q != S_IDLE);
   assign Finished   = (state_q == S_FINISH);
   assign Error      = err_q;
   assign PC         = pc_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Bench for sequenciador_programa: directed scenarios plus randomized programs,
// each run compared against a timeline computed from the sequencing rules.
module tb_sequenciador_programa;

   localparam int WD_LIMIT = 7;

   logic        Clock = 1'b0;
   logic        Reset, LoadEn, Start, ProcDone;
   logic [3:0]  LoadAddr;
   logic [15:0] LoadData;
   logic [4:0]  Length;
   logic [15:0] DIN;
   logic        Run, Busy, Finished, Error;
   logic [3:0]  PC;
   logic [4:0]  InstrCount;

   sequenciador_programa #(.PROG_DEPTH(16), .WD_LIMIT(WD_LIMIT)) dut (
      .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
      .LoadData(LoadData), .Start(Start), .Length(Length), .ProcDone(ProcDone),
      .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished), .Error(Error),
      .PC(PC), .InstrCount(InstrCount)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_mem [16];
   int          model_pc  = 0;
   int          model_cnt = 0;
   int          exp_run_cyc[$];
   logic [15:0] exp_run_din[$];
   logic [15:0] exp_after[$];
   int          exp_fin;
   int          exp_end;
   bit          exp_err;

   // Timeline of one run: cycle 0 is the Start cycle, delays[k] is how many
   // cycles after the k-th instruction enters its wait the processor answers.
   task automatic model_run(input int len, input int delays[$]);
      int leff, pc, cnt, t, d, k, p;
      logic [15:0] w;
      exp_run_cyc.delete(); exp_run_din.delete(); exp_after.delete();
      exp_err = 0; exp_fin = -1;
      leff = (len > 16) ? 16 : len;
      if (leff == 0) begin
         exp_fin = 1; exp_end = 2;
         return;
      end
      pc = 0; cnt = 0; t = 1; k = 0;
      forever begin
         w = exp_mem[pc];
         exp_run_cyc.push_back(t); exp_run_din.push_back(w);
         if (w[8:6] == 3'b001 && pc + 1 >= leff) begin
            exp_after.push_back(16'h0000); exp_err = 1; exp_end = t + 1;
            break;
         end
         if (w[8:6] == 3'b001) begin
            pc++; exp_after.push_back(exp_mem[pc]);
         end else begin
            exp_after.push_back(w);
         end
         d = (k < delays.size()) ? delays[k] : 1000;
         k++;
         if (d >= WD_LIMIT) begin
            exp_err = 1; exp_end = t + 1 + WD_LIMIT;
            break;
         end
         cnt++;
         p = t + 1 + d;
         if (pc + 1 >= leff) begin
            exp_fin = p + 1; exp_end = p + 2;
            break;
         end
         pc++;
         t = p + 1;
      end
      model_pc = pc; model_cnt = cnt;
   endtask

   task automatic load_word(input int addr, input logic [15:0] data);
      @(negedge Clock);
      LoadEn = 1'b1; LoadAddr = addr[3:0]; LoadData = data;
      exp_mem[addr] = data;
      @(negedge Clock);
      LoadEn = 1'b0;
   endtask

   task automatic run_seq(input int len, input int delays[$], input bit disturb, input string tag);
      int          obs_run_cyc[$];
      logic [15:0] obs_din[$];
      logic [15:0] obs_after[$];
      int fin_cnt = 0, fin_cyc = -1, end_c = -1, sched = -1, nrun = 0;
      logic prev_run = 1'b0;
      model_run(len, delays);
      @(negedge Clock);
      Start = 1'b1; Length = len[4:0]; ProcDone = 1'b0;
      for (int c = 1; c < 300; c++) begin
         @(negedge Clock);
         Start = 1'b0; LoadEn = 1'b0; ProcDone = 1'b0;
         if (prev_run) obs_after.push_back(DIN);
         prev_run = Run;
         if (Run) begin
            obs_run_cyc.push_back(c); obs_din.push_back(DIN);
            if (nrun < delays.size()) sched = c + 1 + delays[nrun];
            nrun++;
         end
         if (Finished) begin fin_cnt++; fin_cyc = c; end
         if (!Busy) begin end_c = c; break; end
         if (c == sched) ProcDone = 1'b1;
         if (disturb) begin
            Start = 1'b1; LoadEn = 1'b1;
            LoadAddr = 4'($urandom_range(0, 15)); LoadData = 16'($urandom);
         end
      end
      Start = 1'b0; LoadEn = 1'b0; ProcDone = 1'b0;
      n_checks++;
      if (end_c !== exp_end) begin n_fail++; $display("FAIL %s idle_cycle: got %0d expected %0d", tag, end_c, exp_end); end
      n_checks++;
      if (obs_run_cyc.size() !== exp_run_cyc.size()) begin n_fail++; $display("FAIL %s run_count: got %0d expected %0d", tag, obs_run_cyc.size(), exp_run_cyc.size()); end
      for (int k = 0; k < exp_run_cyc.size() && k < obs_run_cyc.size(); k++) begin
         n_checks++;
         if (obs_run_cyc[k] !== exp_run_cyc[k]) begin n_fail++; $display("FAIL %s run_cycle[%0d]: got %0d expected %0d", tag, k, obs_run_cyc[k], exp_run_cyc[k]); end
         n_checks++;
         if (obs_din[k] !== exp_run_din[k]) begin n_fail++; $display("FAIL %s run_din[%0d]: got %h expected %h", tag, k, obs_din[k], exp_run_din[k]); end
         if (k < obs_after.size()) begin
            n_checks++;
            if (obs_after[k] !== exp_after[k]) begin n_fail++; $display("FAIL %s din_after_run[%0d]: got %h expected %h", tag, k, obs_after[k], exp_after[k]); end
         end
      end
      n_checks++;
      if (fin_cnt !== ((exp_fin >= 0) ? 1 : 0) || fin_cyc !== exp_fin) begin n_fail++; $display("FAIL %s finished: got %0d pulses at %0d expected at %0d", tag, fin_cnt, fin_cyc, exp_fin); end
      n_checks++;
      if (Error !== exp_err) begin n_fail++; $display("FAIL %s error: got %b expected %b", tag, Error, exp_err); end
      n_checks++;
      if (PC !== model_pc[3:0]) begin n_fail++; $display("FAIL %s pc: got %0d expected %0d", tag, PC, model_pc); end
      n_checks++;
      if (InstrCount !== model_cnt[4:0]) begin n_fail++; $display("FAIL %s instr_count: got %0d expected %0d", tag, InstrCount, model_cnt); end
   endtask

   task automatic test_reset();
      Reset = 1'b1; LoadEn = 1'b0; Start = 1'b0; ProcDone = 1'b0;
      LoadAddr = '0; LoadData = '0; Length = '0;
      repeat (2) @(negedge Clock);
      n_checks++;
      if ({DIN, Run, Busy, Finished, Error, PC, InstrCount} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got DIN=%h Run=%b Busy=%b Fin=%b Err=%b PC=%0d Cnt=%0d required all zero", DIN, Run, Busy, Finished, Error, PC, InstrCount);
      end
      Reset = 1'b0;
      model_pc = 0; model_cnt = 0;
   endtask

   task automatic test_mvi_program();
      int q[$];
      load_word(0, 16'h0040); load_word(1, 16'h0005); load_word(2, 16'h0000);
      q.push_back(0); q.push_back(0);
      run_seq(3, q, 1'b0, "mvi_program");
   endtask

   task automatic test_mvi_last();
      int q[$];
      load_word(0, 16'h0040);
      q.push_back(0);
      run_seq(1, q, 1'b0, "mvi_last");
   endtask

   task automatic test_len_zero();
      int q[$];
      run_seq(0, q, 1'b0, "len_zero");
   endtask

   task automatic test_watchdog();
      int q[$];
      load_word(0, 16'h0000);
      q.push_back(1000);
      run_seq(1, q, 1'b0, "watchdog_expire");
      q.delete(); q.push_back(WD_LIMIT - 1);
      run_seq(1, q, 1'b0, "watchdog_edge_done");
   endtask

   task automatic test_reset_mid();
      int q[$];
      load_word(0, 16'h0000); load_word(1, 16'h0080); load_word(2, 16'h01C0);
      @(negedge Clock); Start = 1'b1; Length = 5'd3;
      @(negedge Clock); Start = 1'b0;
      @(negedge Clock); ProcDone = 1'b1;
      @(negedge Clock); ProcDone = 1'b0;
      @(negedge Clock);
      n_checks++;
      if (PC !== 4'd1 || Busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: got PC=%0d Busy=%b expected PC=1 Busy=1", PC, Busy); end
      Reset = 1'b1; Start = 1'b1; ProcDone = 1'b1;
      LoadEn = 1'b1; LoadAddr = 4'd1; LoadData = 16'hBEEF;
      @(negedge Clock);
      Reset = 1'b0; Start = 1'b0; ProcDone = 1'b0; LoadEn = 1'b0;
      n_checks++;
      if ({DIN, Run, Busy, Finished, Error, PC, InstrCount} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got DIN=%h Run=%b Busy=%b Fin=%b Err=%b PC=%0d Cnt=%0d required all zero", DIN, Run, Busy, Finished, Error, PC, InstrCount);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         n_checks++;
         if (Run !== 1'b0 || Busy !== 1'b0 || Finished !== 1'b0) begin n_fail++; $display("FAIL reset_mid_quiet[%0d]: got Run=%b Busy=%b Fin=%b expected 0", i, Run, Busy, Finished); end
      end
      model_pc = 0; model_cnt = 0;
      q.push_back(0); q.push_back(2); q.push_back(1);
      run_seq(3, q, 1'b0, "reset_replay");
   endtask

   task automatic test_busy_ignore();
      int q[$];
      for (int a = 0; a < 4; a++) load_word(a, 16'h0080 + 16'(a));
      q.push_back(1); q.push_back(0); q.push_back(3); q.push_back(2);
      run_seq(4, q, 1'b1, "busy_disturbed");
      run_seq(4, q, 1'b0, "busy_replay");
   endtask

   task automatic test_procdone_idle();
      @(negedge Clock); ProcDone = 1'b1;
      @(negedge Clock); ProcDone = 1'b1;
      @(negedge Clock); ProcDone = 1'b0;
      n_checks++;
      if (Busy !== 1'b0 || Run !== 1'b0 || InstrCount !== model_cnt[4:0] || PC !== model_pc[3:0]) begin
         n_fail++;
         $display("FAIL procdone_idle: got Busy=%b Run=%b Cnt=%0d PC=%0d expected 0 0 %0d %0d", Busy, Run, InstrCount, PC, model_cnt, model_pc);
      end
   endtask

   task automatic test_len_clamp();
      int q[$];
      for (int a = 0; a < 16; a++) begin
         load_word(a, 16'h0100 + 16'(a));
         q.push_back(a % 3);
      end
      run_seq(20, q, 1'b0, "len_clamp");
   endtask

   task automatic test_random();
      int q[$];
      int r;
      logic [15:0] w;
      for (int it = 0; it < 30; it++) begin
         for (int j = 0; j < 4; j++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[8:6] = 3'b001;
            load_word($urandom_range(0, 15), w);
         end
         q.delete();
         for (int j = 0; j < 17; j++) begin
            r = $urandom_range(0, 9);
            q.push_back((r == 0) ? WD_LIMIT + $urandom_range(0, 2) : $urandom_range(0, WD_LIMIT - 1));
         end
         run_seq($urandom_range(0, 20), q, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_mvi_program();
      test_mvi_last();
      test_len_zero();
      test_watchdog();
      test_reset_mid();
      test_busy_ignore();
      test_procdone_idle();
      test_len_clamp();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sequenciador_programa.md
SEQUENCIADOR_PROGRAMA -- requirements
Module: sequenciador_programa

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset. Reset is sampled on the rising edge of Clock.
REQ-002 SHALL have parameter PROG_DEPTH, default 16: number of 16-bit program words stored.
REQ-003 SHALL have parameter WD_LIMIT, default 7: maximum number of cycles to wait for ProcDone.
REQ-004 SHALL have the following ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- LoadEn  in  1  write LoadData to program memory
- LoadAddr  in  4  program memory write address
- LoadData  in  16  program word to write
- Start  in  1  begin sequencing the program
- Length  in  5  number of program words, 0..16
- ProcDone  in  1  Done from the multicycle processor
- DIN  out  16  instruction/immediate word to the processor
- Run  out  1  one-cycle instruction-issue strobe
- Busy  out  1  sequence in progress
- Finished  out  1  one-cycle pulse on normal completion
- Error  out  1  sticky fault flag
- PC  out  4  current program word index
- InstrCount  out  5  instructions retired in the current run

Function
REQ-005 SHALL store PROG_DEPTH x 16-bit words. A write occurs on a rising edge when LoadEn=1 and the block is in IDLE. LoadEn outside IDLE SHALL be ignored.
REQ-006 SHALL implement FSM states IDLE, ISSUE, IMM, WAIT, FINISH. Busy SHALL be 1 in every state except IDLE.
REQ-007 IDLE behaviour:
- Outputs: DIN=0, Run=0.
- Start=1 with Length!=0: PC<=0, InstrCount<=0, Error<=0, go to ISSUE.
- Start=1 with Length=0: Error<=0, go to FINISH; no Run is issued.
REQ-008 Length>16 SHALL be treated as 16.
REQ-009 ISSUE SHALL last exactly one cycle, with Run=1 and DIN=mem[PC].
REQ-010 Opcode is word bits [8:6]; bits [15:9] are ignored. Opcode 3'b001 (mvi) is followed in memory by one immediate word.
REQ-011 Transition out of ISSUE:
- Opcode is mvi and PC+1 < Length: go to IMM, PC<=PC+1.
- Opcode is mvi and PC+1 >= Length: Error<=1, go to IDLE. Run has already pulsed; no immediate word is presented.
- Any other opcode: go to WAIT.
REQ-012 In IMM, DIN SHALL be mem[PC] (the immediate word). In WAIT, DIN SHALL hold mem[PC] (the instruction word). Run=0 in both states.
REQ-013 On ProcDone=1 while in WAIT or IMM:
- InstrCount<=InstrCount+1.
- If PC+1 >= Length: go to FINISH; otherwise PC<=PC+1 and go to ISSUE.
REQ-014 ProcDone SHALL be ignored in IDLE, ISSUE and FINISH.
REQ-015 Watchdog:
- A 3-bit counter clears on entry to WAIT/IMM and increments each cycle spent there without ProcDone.
- When it reaches WD_LIMIT: Error<=1, go to IDLE, no Finished pulse.
- ProcDone arriving in the same cycle the limit is reached SHALL take priority, and the instruction retires normally.
REQ-016 FINISH SHALL last one cycle with Finished=1, then go to IDLE. PC and InstrCount SHALL hold their final values until the next accepted Start.
REQ-017 Start outside IDLE SHALL be ignored.
REQ-018 Error SHALL be sticky until Reset or the next accepted Start.
REQ-019 Latency: Start to the first Run SHALL be exactly 1 cycle. ProcDone to the next Run SHALL be exactly 1 cycle.

Reset
REQ-020 On Reset=1 at a clock edge: state<=IDLE, and DIN, Run, Busy, Finished, Error, PC, InstrCount and the watchdog counter SHALL all be 0.
REQ-021 Reset SHALL NOT alter program memory contents.
REQ-022 Reset mid-sequence SHALL abort immediately. No further Run is issued and no Finished pulse is produced.
REQ-023 Reset SHALL take priority over Start, LoadEn and ProcDone in the same cycle.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, mem[2]=0x0000 (mv R0,R0); Length=3; Start; ProcDone 1 cycle after each Run -> Run pulses exactly twice, DIN sequence 0x0040, 0x0005, 0x0000, then Finished=1 for one cycle, InstrCount=2.
- Length=0; Start -> Finished pulse 1 cycle later, Run never asserted, Error=0.
- Length=1, mem[0]=0x0040 (mvi as last word); Start -> one Run, then Error=1, Busy=0, no Finished.
- Length=1, mem[0]=0x0000; Start; ProcDone held 0 -> Error=1 and return to IDLE exactly WD_LIMIT cycles after entering WAIT.
- Reset asserted during WAIT of a 3-word program -> next cycle all outputs 0 and memory intact; a new Start replays the program from PC=0.
- Start and LoadEn pulsed while Busy=1 -> no effect on the sequence or the memory contents.
